// File: rtl/dff_pipeline_pkg.sv
// Shared constants and helpers for the dff_pipeline slice.
package dff_pipeline_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;

  // Bits needed to count 0..depth valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipeline_stage.sv
// One register stage of dff_pipeline: valid bit plus data word.
module pipe_stage
  import dff_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Reset clears everything; flush drops the entry but keeps data; load shifts in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= prev_valid;
      data  <= prev_data;
    end
  end

endmodule

// File: rtl/dff_pipeline.sv
// Valid/ready register pipeline with a combinational bubble-collapsing
// ready chain. Optional occupancy counter under macro PIPE_OCCUPANCY_EN.
module dff_pipeline
  import dff_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPE_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  logic             v     [DEPTH];
  logic [WIDTH-1:0] d     [DEPTH];
  logic             ready [DEPTH+1];

  assign ready[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // A stage can take new contents if it is empty or its successor moves.
    assign ready[i] = !v[i] || ready[i+1];

    if (i == 0) begin : g_head
      pipe_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .load      (ready[i]),
        .prev_valid(in_valid && !flush),
        .prev_data (in_data),
        .valid     (v[i]),
        .data      (d[i])
      );
    end else begin : g_body
      pipe_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .load      (ready[i]),
        .prev_valid(v[i-1]),
        .prev_data (d[i-1]),
        .valid     (v[i]),
        .data      (d[i])
      );
    end
  end

  assign in_ready  = ready[0] && !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

`ifdef PIPE_OCCUPANCY_EN
  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] occ_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Track valid-stage count from transfer events; flush and reset zero it.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      occ_q <= '0;
    end else if (in_xfer && !out_xfer) begin
      occ_q <= occ_q + OCC_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occ_q <= occ_q - OCC_W'(1);
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_dff_pipeline.sv
// Directed self-checking bench for dff_pipeline (WIDTH=8, DEPTH=4).
// Occupancy checks are active when PIPE_OCCUPANCY_EN is defined.
module tb_dff_pipeline;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
`ifdef PIPE_OCCUPANCY_EN
  logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

  int n_total = 0;
  int n_bad   = 0;

  dff_pipeline #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef PIPE_OCCUPANCY_EN
    ,
    .occupancy(occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_occ(input string tag, input int exp);
`ifdef PIPE_OCCUPANCY_EN
    check(tag, 32'(occupancy), 32'(exp));
`endif
  endtask

  // Stream test expectations, indexed by edge count after the first accept.
  logic       s_valid [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] s_data  [7] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
  logic [7:0] s_in    [3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    int accepted;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset held for two cycles.
    tick();
    tick();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check_occ("rst_occ", 0);
    rst_n = 1'b1;

    // Stream three items with downstream always ready.
    for (int e = 0; e < 7; e++) begin
      if (e < 3) begin
        in_valid = 1'b1;
        in_data  = s_in[e];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
      end
      tick();
      check($sformatf("stream_valid_%0d", e), 32'(out_valid), 32'(s_valid[e]));
      if (s_valid[e])
        check($sformatf("stream_data_%0d", e), 32'(out_data), 32'(s_data[e]));
    end
    check_occ("stream_occ_empty", 0);

    // Stall downstream and push six items; only four fit.
    out_ready = 1'b0;
    accepted  = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(k);
      #1;
      check($sformatf("fill_in_ready_%0d", k), 32'(in_ready), (k < 4) ? 32'd1 : 32'd0);
      if (in_ready) accepted++;
      tick();
    end
    check("fill_accepted", 32'(accepted), 32'd4);
    check("fill_in_ready_full", 32'(in_ready), 32'd0);
    check("fill_out_valid", 32'(out_valid), 32'd1);
    check("fill_head", 32'(out_data), 32'hA0);
    check_occ("fill_occ", 4);

    // Release downstream with upstream still offering: one in, one out per cycle.
    for (int k = 0; k < 6; k++) begin
      in_valid  = 1'b1;
      in_data   = 8'hA4 + 8'(k);
      out_ready = 1'b1;
      #1;
      check($sformatf("thru_in_ready_%0d", k), 32'(in_ready), 32'd1);
      check($sformatf("thru_out_valid_%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("thru_out_data_%0d", k), 32'(out_data), 32'hA0 + 32'(k));
      tick();
      check_occ($sformatf("thru_occ_%0d", k), 4);
    end

    // Drain one entry to leave three in flight (A7, A8, A9).
    in_valid = 1'b0;
    #1;
    check("drain_out_data", 32'(out_data), 32'hA6);
    tick();
    check_occ("drain_occ", 3);

    // Flush with three entries: head still delivered, nothing accepted.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hC5;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_head_valid", 32'(out_valid), 32'd1);
    check("flush_head_data", 32'(out_data), 32'hA7);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check_occ("flush_occ", 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("post_flush_valid_%0d", k), 32'(out_valid), 32'd0);
    end

    // Reset mid-stream with two entries; they must never emerge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hD1;
    tick();
    in_data = 8'hD2;
    tick();
    check_occ("mid_occ", 2);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'h00);
    check_occ("mid_rst_occ", 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("post_rst_valid_%0d", k), 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
